// File: rtl/mimo_pkg.sv
// Shared types and helpers for the K-best MIMO result checker.
package mimo_pkg;

  localparam int unsigned NTX_DEF = 4;
  localparam int unsigned BPS_DEF = 4;
  localparam int unsigned POP_W   = 256;

  typedef logic [BPS_DEF-1:0] sym_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  // Count set bits; callers zero-extend narrower vectors to POP_W.
  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(POP_W); i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mimo_chk_fifo.sv
// Synchronous show-ahead FIFO holding expected frames until the detector catches up.
module mimo_chk_fifo #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Extra MSB distinguishes full from empty when the index bits match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_c = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mimo_result_checker.sv
// Scoreboard aligning expected symbols to detector output through an elastic FIFO.
module mimo_result_checker
  import mimo_pkg::*;
#(
  parameter int unsigned NTX   = NTX_DEF,
  parameter int unsigned BPS   = BPS_DEF,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_frames,
  input  logic               exp_valid,
  input  logic [NTX*BPS-1:0] exp_x,
  input  logic               det_valid,
  input  logic [NTX*BPS-1:0] det_x,
  output logic               err_valid,
  output logic [NTX-1:0]     err_sym,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   sym_err_cnt,
  output logic [CNT_W-1:0]   bit_err_cnt,
  output logic [CNT_W-1:0]   first_err_idx,
  output logic               fail,
  output logic               overflow,
  output logic               underflow,
  output logic               busy,
  output logic               done
);

  localparam int unsigned W = NTX * BPS;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e       state, state_nxt;
  logic [CNT_W-1:0] num_lat;
  logic [W-1:0]     head;
  logic             full, empty;
  logic             run, pop_en, push_en, ovf_set, unf_set;
  logic [W-1:0]     diff;
  logic [NTX-1:0]   err_sym_nxt;
  logic [CNT_W-1:0] frame_nxt, sym_nxt, bit_nxt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned b);
    logic [63:0] s;
    s = 64'(a) + 64'(b);
    return (s > 64'(CNT_MAX)) ? CNT_MAX : CNT_W'(s);
  endfunction

  mimo_chk_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (start),
    .push   (push_en),
    .pop    (pop_en),
    .din    (exp_x),
    .head_c (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // start outranks same-cycle traffic: the FIFO flush and counter clear win.
  always_comb begin
    state_nxt   = state;
    run         = (state == ST_RUN) && !start;
    pop_en      = run && det_valid && !empty;
    push_en     = run && exp_valid && (!full || pop_en);
    ovf_set     = run && exp_valid && full && !pop_en;
    unf_set     = run && det_valid && empty;
    diff        = head ^ det_x;
    err_sym_nxt = '0;
    for (int i = 0; i < int'(NTX); i++) err_sym_nxt[i] = |diff[i*BPS +: BPS];
    frame_nxt   = sat_add(frame_cnt, 1);
    sym_nxt     = sat_add(sym_err_cnt, popcount(POP_W'(err_sym_nxt)));
    bit_nxt     = sat_add(bit_err_cnt, popcount(POP_W'(diff)));
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (start) state_nxt = ST_RUN;
        else if (pop_en && (num_lat != '0) && (frame_nxt == num_lat)) state_nxt = ST_DONE;
      end
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_lat       <= '0;
      err_valid     <= 1'b0;
      err_sym       <= '0;
      frame_cnt     <= '0;
      sym_err_cnt   <= '0;
      bit_err_cnt   <= '0;
      first_err_idx <= '0;
      fail          <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      busy <= (state_nxt == ST_RUN);
      done <= (state_nxt == ST_DONE);
      if (start) begin
        num_lat       <= num_frames;
        err_valid     <= 1'b0;
        err_sym       <= '0;
        frame_cnt     <= '0;
        sym_err_cnt   <= '0;
        bit_err_cnt   <= '0;
        first_err_idx <= '0;
        fail          <= 1'b0;
        overflow      <= 1'b0;
        underflow     <= 1'b0;
      end else begin
        err_valid <= pop_en;
        if (pop_en) begin
          err_sym     <= err_sym_nxt;
          frame_cnt   <= frame_nxt;
          sym_err_cnt <= sym_nxt;
          bit_err_cnt <= bit_nxt;
          if ((|err_sym_nxt) && !fail) begin
            first_err_idx <= frame_cnt;
            fail          <= 1'b1;
          end
        end
        if (ovf_set) overflow  <= 1'b1;
        if (unf_set) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mimo_result_checker.sv
// Directed self-checking bench for mimo_result_checker (default build plus a 4-bit counter build).
module tb_mimo_result_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_frames;
  logic        exp_valid;
  logic [15:0] exp_x;
  logic        det_valid;
  logic [15:0] det_x;

  logic        err_valid, fail, overflow, underflow, busy, done;
  logic [3:0]  err_sym;
  logic [31:0] frame_cnt, sym_err_cnt, bit_err_cnt, first_err_idx;

  logic        s_err_valid, s_fail, s_overflow, s_underflow, s_busy, s_done;
  logic [3:0]  s_err_sym;
  logic [3:0]  s_frame_cnt, s_sym_err_cnt, s_bit_err_cnt, s_first_err_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mimo_result_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .exp_valid(exp_valid), .exp_x(exp_x), .det_valid(det_valid), .det_x(det_x),
    .err_valid(err_valid), .err_sym(err_sym), .frame_cnt(frame_cnt),
    .sym_err_cnt(sym_err_cnt), .bit_err_cnt(bit_err_cnt), .first_err_idx(first_err_idx),
    .fail(fail), .overflow(overflow), .underflow(underflow), .busy(busy), .done(done)
  );

  mimo_result_checker #(.DEPTH(8), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_frames(4'(num_frames)),
    .exp_valid(exp_valid), .exp_x(exp_x), .det_valid(det_valid), .det_x(det_x),
    .err_valid(s_err_valid), .err_sym(s_err_sym), .frame_cnt(s_frame_cnt),
    .sym_err_cnt(s_sym_err_cnt), .bit_err_cnt(s_bit_err_cnt), .first_err_idx(s_first_err_idx),
    .fail(s_fail), .overflow(s_overflow), .underflow(s_underflow), .busy(s_busy), .done(s_done)
  );

  function automatic logic [15:0] fr(input int i);
    return 16'(i * 40503 + 7);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 1'b0; exp_valid = 1'b0; det_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] n);
    idle_in();
    num_frames = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; num_frames = '0;
    exp_valid = 1'b0; exp_x = '0; det_valid = 1'b0; det_x = '0;
    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_frame", 64'(frame_cnt), 0);
    chk("rst_fail", 64'(fail), 0);
    rst = 1'b1;
    tick();

    // Traffic in IDLE must be ignored.
    det_valid = 1'b1; det_x = 16'h1234; exp_valid = 1'b1;
    tick();
    idle_in();
    chk("idle_underflow", 64'(underflow), 0);
    chk("idle_err_valid", 64'(err_valid), 0);

    // Delay match: expected stream leads detector stream by 122 cycles.
    pulse_start(32'd200);
    chk("dm_busy", 64'(busy), 1);
    for (int t = 0; t < 322; t++) begin
      exp_valid = (t < 200);
      exp_x     = fr(t);
      det_valid = (t >= 122);
      det_x     = fr(t - 122);
      tick();
      if (t == 122) chk("dm_first_ev", 64'(err_valid), 1);
      if (t == 320) begin
        chk("dm_frame_199", 64'(frame_cnt), 199);
        chk("dm_done_early", 64'(done), 0);
      end
    end
    idle_in();
    chk("dm_frame", 64'(frame_cnt), 200);
    chk("dm_sym", 64'(sym_err_cnt), 0);
    chk("dm_fail", 64'(fail), 0);
    chk("dm_done", 64'(done), 1);
    chk("dm_busy_end", 64'(busy), 0);
    chk("dm_ovf", 64'(overflow), 0);

    // Ignored while DONE.
    det_valid = 1'b1; det_x = 16'hFFFF;
    tick();
    idle_in();
    chk("done_ign_frame", 64'(frame_cnt), 200);
    chk("done_ign_ev", 64'(err_valid), 0);

    // Injected error on frame 5.
    pulse_start(32'd10);
    for (int t = 0; t < 11; t++) begin
      exp_valid = (t < 10);
      exp_x     = fr(t + 1000);
      det_valid = (t >= 1);
      det_x     = fr(t - 1 + 1000) ^ ((t - 1 == 5) ? 16'h0103 : 16'h0000);
      tick();
      if (t == 6) begin
        chk("inj_ev", 64'(err_valid), 1);
        chk("inj_err_sym", 64'(err_sym), 4'b0101);
        chk("inj_first_idx", 64'(first_err_idx), 5);
        chk("inj_fail", 64'(fail), 1);
        chk("inj_bits", 64'(bit_err_cnt), 3);
      end
      if (t == 7) chk("inj_err_sym_clr", 64'(err_sym), 0);
    end
    idle_in();
    tick();
    chk("inj_frame", 64'(frame_cnt), 10);
    chk("inj_sym", 64'(sym_err_cnt), 2);
    chk("inj_bit", 64'(bit_err_cnt), 3);
    chk("inj_first_hold", 64'(first_err_idx), 5);
    chk("inj_done", 64'(done), 1);
    chk("inj_ev_pulse", 64'(err_valid), 0);

    // Overflow: 130 pushes, free-run, then drain the retained 128.
    pulse_start(32'd0);
    for (int t = 0; t < 130; t++) begin
      exp_valid = 1'b1;
      exp_x     = fr(t + 2000);
      tick();
      if (t == 127) chk("ovf_not_yet", 64'(overflow), 0);
    end
    idle_in();
    chk("ovf_set", 64'(overflow), 1);
    for (int t = 0; t < 128; t++) begin
      det_valid = 1'b1;
      det_x     = fr(t + 2000);
      tick();
    end
    idle_in();
    chk("ovf_frame", 64'(frame_cnt), 128);
    chk("ovf_sym", 64'(sym_err_cnt), 0);
    chk("ovf_fail", 64'(fail), 0);
    chk("ovf_busy", 64'(busy), 1);
    chk("unf_before", 64'(underflow), 0);

    // Underflow: det_valid with empty FIFO.
    det_valid = 1'b1; det_x = 16'h5555;
    tick();
    idle_in();
    chk("unf_set", 64'(underflow), 1);
    chk("unf_frame", 64'(frame_cnt), 128);
    chk("unf_ev", 64'(err_valid), 0);

    // Restart at frame 50 of a 100-frame run.
    pulse_start(32'd100);
    for (int t = 0; t < 51; t++) begin
      exp_valid = 1'b1;
      exp_x     = fr(t + 3000);
      det_valid = (t >= 1);
      det_x     = fr(t - 1 + 3000);
      tick();
    end
    idle_in();
    chk("rs_mid_frame", 64'(frame_cnt), 50);
    pulse_start(32'd100);
    chk("rs_frame0", 64'(frame_cnt), 0);
    chk("rs_unf0", 64'(underflow), 0);
    chk("rs_busy", 64'(busy), 1);
    det_valid = 1'b1; det_x = fr(3050);
    tick();
    idle_in();
    chk("rs_flushed", 64'(underflow), 1);
    chk("rs_frame_still0", 64'(frame_cnt), 0);
    for (int t = 0; t < 101; t++) begin
      exp_valid = (t < 100);
      exp_x     = fr(t + 4000);
      det_valid = (t >= 1);
      det_x     = fr(t - 1 + 4000);
      tick();
    end
    idle_in();
    chk("rs_frame", 64'(frame_cnt), 100);
    chk("rs_done", 64'(done), 1);
    chk("rs_sym", 64'(sym_err_cnt), 0);

    // Saturation: two all-wrong frames.
    pulse_start(32'd2);
    exp_valid = 1'b1; exp_x = fr(7);
    tick();
    exp_x = fr(8); det_valid = 1'b1; det_x = ~fr(7);
    tick();
    chk("sat_bit1_small", 64'(s_bit_err_cnt), 15);
    exp_valid = 1'b0; det_x = ~fr(8);
    tick();
    idle_in();
    chk("sat_bit_small", 64'(s_bit_err_cnt), 15);
    chk("sat_sym_small", 64'(s_sym_err_cnt), 8);
    chk("sat_frame_small", 64'(s_frame_cnt), 2);
    chk("sat_done_small", 64'(s_done), 1);
    chk("sat_bit_wide", 64'(bit_err_cnt), 32);
    chk("sat_sym_wide", 64'(sym_err_cnt), 8);
    chk("sat_first_idx", 64'(first_err_idx), 0);

    // Asynchronous reset mid-session.
    pulse_start(32'd0);
    exp_valid = 1'b1; exp_x = fr(9);
    tick();
    idle_in();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 0);
    chk("arst_fail", 64'(fail), 0);
    chk("arst_bit", 64'(bit_err_cnt), 0);
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
